// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, synchronous flush,
// saturating ADD/SUB and an NZV flag register updated when a result retires.
module alu_pipe #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ALU_in1,
  input  logic [WIDTH-1:0] ALU_in2,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic [2:0]       res_flag,
  output logic [2:0]       flag_write,
  output logic [2:0]       flag
);

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_RED    = 3'b010,
    OP_XOR    = 3'b011,
    OP_SLL    = 3'b100,
    OP_SRA    = 3'b101,
    OP_ROR    = 3'b110,
    OP_PADDSB = 3'b111
  } op_e;

  localparam int NBYTES = WIDTH / 8;
  localparam int NLANES = WIDTH / 4;
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_load;
  logic             s2_load;
  logic             retire;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;

  // ---------------------------------------------------------------------------
  // Handshake and stage control
  // ---------------------------------------------------------------------------
  assign s2_load   = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | s2_load;
  assign s1_load   = in_valid & in_ready;
  assign out_valid = s2_valid;
  assign retire    = s2_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load)      s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;
      if (s2_load)        s2_valid <= 1'b1;
      else if (out_ready) s2_valid <= 1'b0;
    end
  end

  // NOTE: operand registers carry no reset; nothing reads them unless s1_valid is set.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_a  <= ALU_in1;
      s1_b  <= ALU_in2;
      s1_op <= op_e'(op);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH:0]   as_ext;
  logic             as_ovf;
  logic [WIDTH-1:0] as_sat;

  // One extra sign bit makes overflow visible, including A - (most negative B).
  assign add_ext = {s1_a[WIDTH-1], s1_a} + {s1_b[WIDTH-1], s1_b};
  assign sub_ext = {s1_a[WIDTH-1], s1_a} - {s1_b[WIDTH-1], s1_b};

  always_comb begin
    as_ext = (s1_op == OP_SUB) ? sub_ext : add_ext;
    as_ovf = as_ext[WIDTH] ^ as_ext[WIDTH-1];
    if (!as_ovf)            as_sat = as_ext[WIDTH-1:0];
    else if (as_ext[WIDTH]) as_sat = SAT_NEG;
    else                    as_sat = SAT_POS;
  end

  logic [WIDTH-1:0] red_sum;

  always_comb begin
    // NOTE: blocking '=' is right here: each iteration must see the previous partial
    // sum. Every clocked register in this file uses '<=' instead.
    red_sum = '0;
    for (int i = 0; i < NBYTES; i++) begin
      red_sum = red_sum
              + {{(WIDTH-8){s1_a[8*i+7]}}, s1_a[8*i +: 8]}
              + {{(WIDTH-8){s1_b[8*i+7]}}, s1_b[8*i +: 8]};
    end
  end

  logic [WIDTH-1:0] padd;

  always_comb begin
    logic [4:0] lane_sum;
    padd     = '0;
    lane_sum = '0;
    for (int i = 0; i < NLANES; i++) begin
      lane_sum = {s1_a[4*i+3], s1_a[4*i +: 4]} + {s1_b[4*i+3], s1_b[4*i +: 4]};
      if (lane_sum[4] != lane_sum[3]) padd[4*i +: 4] = lane_sum[4] ? 4'b1000 : 4'b0111;
      else                            padd[4*i +: 4] = lane_sum[3:0];
    end
  end

  logic [SHW-1:0]   sh;
  logic [SHW-1:0]   rol_sh;
  logic [WIDTH-1:0] sll_res;
  logic [WIDTH-1:0] sra_res;
  logic [WIDTH-1:0] ror_res;

  // Left-shift for the wrap-around part is -sh mod WIDTH, so sh=0 leaves A intact.
  assign sh      = s1_b[SHW-1:0];
  assign rol_sh  = -sh;
  assign sll_res = s1_a << sh;
  assign sra_res = $signed(s1_a) >>> sh;
  assign ror_res = (s1_a >> sh) | (s1_a << rol_sh);

  logic [WIDTH-1:0] res;
  logic             res_v;
  logic [2:0]       res_mask;

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    res      = '0;
    res_v    = 1'b0;
    res_mask = 3'b010;
    case (s1_op)
      OP_ADD, OP_SUB: begin
        res      = as_sat;
        res_v    = as_ovf;
        res_mask = 3'b111;
      end
      OP_RED:    res = red_sum;
      OP_XOR:    res = s1_a ^ s1_b;
      OP_SLL:    res = sll_res;
      OP_SRA:    res = sra_res;
      OP_ROR:    res = ror_res;
      OP_PADDSB: res = padd;
      default:   res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result and architectural flag registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_out    <= '0;
      res_flag   <= '0;
      flag_write <= '0;
    end else if (s2_load && !flush) begin
      ALU_out    <= res;
      res_flag   <= {res[WIDTH-1], (res == '0), res_v};
      flag_write <= res_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 3'b000;
    end else if (retire) begin
      flag <= (flag & ~flag_write) | (res_flag & flag_write);
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed known answers plus randomized traffic
// scored against an arithmetic reference model and a queue of in-flight ops.
module tb_alu_pipe;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, RED = 3'd2, XOR = 3'd3;
  localparam logic [2:0] SLL = 3'd4, SRA = 3'd5, ROR = 3'd6, PADDSB = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] ALU_in1 = '0;
  logic [15:0] ALU_in2 = '0;
  logic [2:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] ALU_out;
  logic [2:0]  res_flag, flag_write, flag;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [31:0] w_in1 = '0;
  logic [31:0] w_in2 = '0;
  logic [2:0]  w_op = '0;
  logic        w_out_valid;
  logic [31:0] w_out;
  logic [2:0]  w_res_flag, w_flag_write, w_flag;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_in1(ALU_in1), .ALU_in2(ALU_in2), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .ALU_out(ALU_out), .res_flag(res_flag),
    .flag_write(flag_write), .flag(flag)
  );

  alu_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .ALU_in1(w_in1), .ALU_in2(w_in2), .op(w_op), .out_valid(w_out_valid),
    .out_ready(1'b1), .ALU_out(w_out), .res_flag(w_res_flag),
    .flag_write(w_flag_write), .flag(w_flag)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode's definition.
  function automatic longint sfield(input logic [31:0] x, input int pos, input int bits);
    longint f;
    f = longint'((x >> pos) & ((32'd1 << bits) - 32'd1));
    return (f >= (longint'(1) << (bits - 1))) ? f - (longint'(1) << bits) : f;
  endfunction

  function automatic void model(input int w, input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic [2:0] nzv, output logic [2:0] mask);
    longint modv, maxv, minv, sa, sb, la, lb, s, l;
    int sh;
    bit v;
    modv = longint'(1) << w;
    maxv = modv / 2 - 1;
    minv = -(modv / 2);
    la = longint'(a);
    lb = longint'(b);
    sa = (la > maxv) ? la - modv : la;
    sb = (lb > maxv) ? lb - modv : lb;
    sh = int'(lb % longint'(w));
    v = 1'b0;
    mask = 3'b010;
    s = 0;
    case (o)
      ADD, SUB: begin
        s = (o == ADD) ? sa + sb : sa - sb;
        mask = 3'b111;
        if (s > maxv)      begin s = maxv; v = 1'b1; end
        else if (s < minv) begin s = minv; v = 1'b1; end
      end
      RED: for (int i = 0; i < w / 8; i++) s += sfield(a, 8 * i, 8) + sfield(b, 8 * i, 8);
      XOR: s = la ^ lb;
      SLL: s = la << sh;
      SRA: s = sa >>> sh;
      ROR: s = (la >> sh) | (la << (w - sh));
      default: begin
        for (int i = 0; i < w / 4; i++) begin
          l = sfield(a, 4 * i, 4) + sfield(b, 4 * i, 4);
          if (l > 7)  l = 7;
          if (l < -8) l = -8;
          s |= (l & 15) << (4 * i);
        end
      end
    endcase
    r = 32'(s & (modv - 1));
    nzv = {r[w-1], r == 32'd0, v};
  endfunction

  typedef struct {
    logic [31:0] r;
    logic [2:0]  nzv;
    logic [2:0]  mask;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          edge_cnt = 0;
  logic [2:0]  mflag = 3'b000;
  bit          hold_pending = 1'b0;
  bit          last_acc = 1'b0;
  logic [15:0] h_out;
  logic [2:0]  h_rf, h_fw;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // One clock of the 16-bit pipe: drive, check handshakes/results, track the model.
  task automatic cycle(input bit v, input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b, input bit ordy, input bit fl);
    exp_t e;
    bit   ev;
    @(negedge clk);
    in_valid = v; op = o; ALU_in1 = a; ALU_in2 = b; out_ready = ordy; flush = fl;
    #1;
    ev = (q.size() > 0) && (edge_cnt >= q[0].acc + 2);
    check("in_ready", in_ready, (q.size() < 2) || ordy);
    check("out_valid", out_valid, ev);
    if (hold_pending) begin
      check("hold_out", ALU_out, h_out);
      check("hold_flags", {res_flag, flag_write}, {h_rf, h_fw});
    end
    hold_pending = ev && !ordy && !fl;
    h_out = ALU_out; h_rf = res_flag; h_fw = flag_write;
    if (ev && ordy && !fl) begin
      e = q.pop_front();
      check("result", ALU_out, e.r);
      check("res_flag", res_flag, e.nzv);
      check("flag_write", flag_write, e.mask);
      for (int i = 0; i < 3; i++) if (e.mask[i]) mflag[i] = e.nzv[i];
    end
    last_acc = v && in_ready && !fl;
    if (fl) q.delete();
    else if (last_acc) begin
      model(16, o, a, b, e.r, e.nzv, e.mask);
      e.acc = edge_cnt;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    check("flag", flag, mflag);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, ADD, 16'h0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic kat(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] exp_r, input logic [2:0] exp_flag);
    cycle(1'b1, o, a, b, 1'b1, 1'b0);
    check("kat_early", out_valid, 1'b0);
    idle(1);
    check("kat_valid", out_valid, 1'b1);
    check("kat_out", ALU_out, exp_r);
    idle(1);
    check("kat_flag", flag, exp_flag);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 10) begin idle(1); n++; end
    check("drain", q.size(), 0);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; w_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_alu_out", ALU_out, 16'h0);
    check("rst_res_flag", {res_flag, flag_write}, 6'b0);
    check("rst_flag", flag, 3'b000);
    q.delete(); mflag = 3'b000; hold_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic k32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_r, input logic [2:0] exp_flag);
    logic [31:0] mr;
    logic [2:0]  mn, mm;
    int          n;
    model(32, o, a, b, mr, mn, mm);
    @(negedge clk);
    w_in_valid = 1'b1; w_op = o; w_in1 = a; w_in2 = b;
    #1 check("w32_ready", w_in_ready, 1'b1);
    @(negedge clk);
    w_in_valid = 1'b0;
    n = 0;
    while (!w_out_valid && n < 5) begin @(negedge clk); n++; end
    check("w32_latency", n, 1);
    check("w32_out", w_out, exp_r);
    check("w32_model", w_out, mr);
    check("w32_res_flag", w_res_flag, mn);
    check("w32_flag_write", w_flag_write, mm);
    @(posedge clk);
    #1 check("w32_flag", w_flag, exp_flag);
  endtask

  function automatic logic [15:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  logic [2:0]  st_op [4] = '{XOR, SLL, ROR, SRA};
  logic [15:0] st_a  [4] = '{16'h1234, 16'h0003, 16'h0010, 16'h4000};
  logic [15:0] st_b  [4] = '{16'h00F0, 16'h0002, 16'h0004, 16'h0002};

  initial begin
    logic [15:0] sv_out;
    logic [2:0]  sv_rf;
    int          i, cyc;

    apply_reset();

    kat(ADD,    16'h0003, 16'h0004, 16'h0007, 3'b000);
    kat(ADD,    16'h7FFF, 16'h0001, 16'h7FFF, 3'b001);
    kat(SUB,    16'h8000, 16'h0001, 16'h8000, 3'b101);
    kat(XOR,    16'h00FF, 16'h00FF, 16'h0000, 3'b111);
    kat(ROR,    16'h8001, 16'h0001, 16'hC000, 3'b101);
    kat(SRA,    16'h8000, 16'h000F, 16'hFFFF, 3'b101);
    kat(PADDSB, 16'h7878, 16'h1111, 16'h7979, 3'b101);
    kat(RED,    16'h7F7F, 16'h0101, 16'h0100, 3'b101);
    kat(SUB,    16'h0000, 16'h8000, 16'h7FFF, 3'b001);
    kat(SLL,    16'h1234, 16'h0000, 16'h1234, 3'b001);

    // Four back-to-back ops with the consumer stalled for three cycles.
    i = 0;
    cyc = 0;
    while (i < 4 && cyc < 20) begin
      cycle(1'b1, st_op[i], st_a[i], st_b[i], cyc >= 3, 1'b0);
      if (last_acc) i++;
      cyc++;
      if (cyc == 3) check("stall_accepts", i, 2);
    end
    drain();
    check("stall_flag", flag, 3'b001);

    // Flush with both stages full while the consumer is ready.
    cycle(1'b1, ADD, 16'h0001, 16'h0002, 1'b0, 1'b0);
    cycle(1'b1, SUB, 16'h0005, 16'h0003, 1'b0, 1'b0);
    sv_out = ALU_out;
    sv_rf  = res_flag;
    cycle(1'b1, XOR, 16'h0003, 16'h0005, 1'b1, 1'b1);
    check("flush_valid", out_valid, 1'b0);
    check("flush_hold_out", ALU_out, sv_out);
    check("flush_hold_rf", res_flag, sv_rf);
    check("flush_flag", flag, 3'b001);
    kat(ADD, 16'h0010, 16'h0020, 16'h0030, 3'b000);

    repeat (1500) begin
      cycle($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(),
            $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
    end
    drain();

    // Reset with ops in flight and a nonzero flag register.
    kat(ADD, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b001);
    cycle(1'b1, XOR, 16'h0001, 16'h0002, 1'b0, 1'b0);
    cycle(1'b1, XOR, 16'h0004, 16'h0008, 1'b0, 1'b0);
    apply_reset();
    kat(ADD, 16'h0003, 16'h0004, 16'h0007, 3'b000);

    k32(SLL,    32'h0000_0001, 32'd31,        32'h8000_0000, 3'b000);
    k32(ADD,    32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 3'b001);
    k32(SUB,    32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 3'b101);
    k32(RED,    32'h8080_8080, 32'h8080_8080, 32'hFFFF_FC00, 3'b101);
    k32(PADDSB, 32'h7777_7777, 32'h1111_1111, 32'h7777_7777, 3'b101);
    k32(ROR,    32'h0000_0001, 32'd4,         32'h1000_0000, 3'b101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
